// File: rtl/regwr_onehot_decoder.sv
// Multi-port register-file write-enable decoder with registered output and 2-entry skid buffer.
// Optional ZERO_REG_MASK_EN: never write register 0 (address 0 writes are ignored entirely).
module regwr_onehot_decoder #(
    parameter int ADDR_W = 5,
    parameter int PORTS  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PORTS-1:0]          wr_en,
    input  logic [PORTS*ADDR_W-1:0]   wr_addr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [(1<<ADDR_W)-1:0]    we_vec,
    output logic                      conflict,
    output logic [CNT_W-1:0]          wr_count
);

    localparam int NREG = 1 << ADDR_W;

`ifdef ZERO_REG_MASK_EN
    localparam bit ZERO_MASK = 1'b1;
`else
    localparam bit ZERO_MASK = 1'b0;
`endif

    logic [NREG-1:0]  dec_vec;
    logic             dec_conflict;
    logic             dec_any;

    logic             out_valid_q, out_valid_d;
    logic [NREG-1:0]  out_vec_q, out_vec_d;
    logic             out_conflict_q, out_conflict_d;
    logic             skid_valid_q, skid_valid_d;
    logic [NREG-1:0]  skid_vec_q, skid_vec_d;
    logic             skid_conflict_q, skid_conflict_d;
    logic [CNT_W-1:0] wr_count_q, wr_count_d;

    logic             accept;
    logic             out_free;

    always_comb begin
        dec_vec      = '0;
        dec_conflict = 1'b0;
        for (int p = 0; p < PORTS; p++) begin
            if (wr_en[p]) begin
                dec_vec[wr_addr[p*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
        // A masked register-0 collision is not a real hazard since neither write lands.
        for (int p = 0; p < PORTS; p++) begin
            for (int r = p + 1; r < PORTS; r++) begin
                if (wr_en[p] && wr_en[r] &&
                    (wr_addr[p*ADDR_W +: ADDR_W] == wr_addr[r*ADDR_W +: ADDR_W]) &&
                    (!ZERO_MASK || (wr_addr[p*ADDR_W +: ADDR_W] != '0))) begin
                    dec_conflict = 1'b1;
                end
            end
        end
        if (ZERO_MASK) begin
            dec_vec[0] = 1'b0;
        end
        dec_any = |dec_vec;
    end

    assign accept   = in_valid & in_ready;
    assign out_free = ~out_valid_q | out_ready;

    // OUT refills from SKID first to preserve order; SKID only fills when OUT is stalled.
    always_comb begin
        out_valid_d     = out_valid_q;
        out_vec_d       = out_vec_q;
        out_conflict_d  = out_conflict_q;
        skid_valid_d    = skid_valid_q;
        skid_vec_d      = skid_vec_q;
        skid_conflict_d = skid_conflict_q;
        wr_count_d      = wr_count_q;

        if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d    = 1'b1;
                out_vec_d      = skid_vec_q;
                out_conflict_d = skid_conflict_q;
                skid_valid_d   = 1'b0;
            end else if (accept) begin
                out_valid_d    = 1'b1;
                out_vec_d      = dec_vec;
                out_conflict_d = dec_conflict;
            end else begin
                out_valid_d    = 1'b0;
                out_vec_d      = '0;
                out_conflict_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d    = 1'b1;
            skid_vec_d      = dec_vec;
            skid_conflict_d = dec_conflict;
        end

        if (accept && dec_any && (wr_count_q != {CNT_W{1'b1}})) begin
            wr_count_d = wr_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q     <= 1'b0;
            out_vec_q       <= '0;
            out_conflict_q  <= 1'b0;
            skid_valid_q    <= 1'b0;
            skid_vec_q      <= '0;
            skid_conflict_q <= 1'b0;
            wr_count_q      <= '0;
        end else begin
            out_valid_q     <= out_valid_d;
            out_vec_q       <= out_vec_d;
            out_conflict_q  <= out_conflict_d;
            skid_valid_q    <= skid_valid_d;
            skid_vec_q      <= skid_vec_d;
            skid_conflict_q <= skid_conflict_d;
            wr_count_q      <= wr_count_d;
        end
    end

    assign in_ready  = ~skid_valid_q & ~reset;
    assign out_valid = out_valid_q;
    assign we_vec    = out_vec_q;
    assign conflict  = out_conflict_q;
    assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_regwr_onehot_decoder.sv
// Self-checking bench for regwr_onehot_decoder: directed plan steps plus randomized traffic
// checked against a queue-based reference model. Honours ZERO_REG_MASK_EN when defined.
module tb_regwr_onehot_decoder;

    localparam int ADDR_W = 5;
    localparam int PORTS  = 2;
    localparam int NREG   = 1 << ADDR_W;

`ifdef ZERO_REG_MASK_EN
    localparam bit ZERO_MASK = 1'b1;
`else
    localparam bit ZERO_MASK = 1'b0;
`endif

    typedef struct {
        logic [NREG-1:0] vec;
        logic            conf;
    } beat_t;

    logic                    clk;
    logic                    reset;
    logic                    in_valid;
    logic                    in_ready;
    logic [PORTS-1:0]        wr_en;
    logic [PORTS*ADDR_W-1:0] wr_addr;
    logic                    out_valid;
    logic                    out_ready;
    logic [NREG-1:0]         we_vec;
    logic                    conflict;
    logic [15:0]             wr_count;

    logic                    s_in_ready;
    logic                    s_out_valid;
    logic [NREG-1:0]         s_we_vec;
    logic                    s_conflict;
    logic [1:0]              s_wr_count;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];
    int    cnt = 0;
    bit    last_accept = 1'b0;

    regwr_onehot_decoder #(.ADDR_W(ADDR_W), .PORTS(PORTS), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .out_valid(out_valid), .out_ready(out_ready),
        .we_vec(we_vec), .conflict(conflict), .wr_count(wr_count)
    );

    regwr_onehot_decoder #(.ADDR_W(ADDR_W), .PORTS(PORTS), .CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .out_valid(s_out_valid), .out_ready(out_ready),
        .we_vec(s_we_vec), .conflict(s_conflict), .wr_count(s_wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode: count hits per register, then derive the vector and collisions.
    task automatic model_decode(input logic [PORTS-1:0] en, input logic [PORTS*ADDR_W-1:0] addr,
                                output logic [NREG-1:0] vec, output logic conf);
        int hits[NREG];
        int a;
        for (int i = 0; i < NREG; i++) hits[i] = 0;
        for (int p = 0; p < PORTS; p++) begin
            a = int'(addr[p*ADDR_W +: ADDR_W]);
            if (en[p] && !(ZERO_MASK && a == 0)) hits[a] = hits[a] + 1;
        end
        vec  = '0;
        conf = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (hits[i] > 0) vec[i] = 1'b1;
            if (hits[i] > 1) conf = 1'b1;
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [PORTS-1:0] en,
                                  input int a0, input int a1, input logic ordy);
        in_valid  = v;
        wr_en     = en;
        wr_addr   = {ADDR_W'(a1), ADDR_W'(a0)};
        out_ready = ordy;
    endtask

    task automatic check_output();
        chk("in_ready", in_ready, exp_q.size() < 2);
        chk("out_valid", out_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            chk("we_vec", we_vec, exp_q[0].vec);
            chk("conflict", conflict, exp_q[0].conf);
        end
        chk("wr_count", wr_count, cnt);
        chk("small_wr_count", s_wr_count, (cnt > 3) ? 3 : cnt);
        chk("small_out_valid", s_out_valid, out_valid);
        chk("small_in_ready", s_in_ready, exp_q.size() < 2);
        if (exp_q.size() > 0) begin
            chk("small_we_vec", s_we_vec, exp_q[0].vec);
            chk("small_conflict", s_conflict, exp_q[0].conf);
        end
    endtask

    task automatic step();
        logic  acc;
        logic  cons;
        beat_t b;
        @(negedge clk);
        check_output();
        acc  = in_valid && (exp_q.size() < 2);
        cons = (exp_q.size() > 0) && out_ready;
        @(posedge clk);
        if (cons) void'(exp_q.pop_front());
        if (acc) begin
            model_decode(wr_en, wr_addr, b.vec, b.conf);
            exp_q.push_back(b);
            if (b.vec != '0 && cnt < 65535) cnt++;
        end
        last_accept = acc;
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_we_vec"}, we_vec, '0);
        chk({tag, "_conflict"}, conflict, 1'b0);
        chk({tag, "_wr_count"}, wr_count, '0);
        chk({tag, "_in_ready"}, in_ready, 1'b0);
    endtask

    initial begin
        int a0;
        int a1;
        int guard;
        reset = 1'b1;
        apply_stimulus(1'b0, '0, 0, 0, 1'b1);
        #3;
        check_reset_state("por");
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        // Plan beat: two ports, distinct addresses.
        apply_stimulus(1'b1, 2'b11, 3, 17, 1'b1);
        step();
        chk("plan_vec_3_17", we_vec, 32'h0002_0008);
        chk("plan_conflict_3_17", conflict, 1'b0);
        chk("plan_count_1", wr_count, 1);

        apply_stimulus(1'b1, 2'b11, 9, 9, 1'b1);
        step();
        chk("plan_vec_same", we_vec, 32'h0000_0200);
        chk("plan_conflict_same", conflict, 1'b1);

        // Stall with three beats queued behind a blocked consumer.
        apply_stimulus(1'b1, 2'b01, 1, 0, 1'b0);
        step();
        apply_stimulus(1'b1, 2'b01, 2, 0, 1'b0);
        step();
        chk("stall_in_ready_low", in_ready, 1'b0);
        apply_stimulus(1'b1, 2'b01, 4, 0, 1'b0);
        step();
        step();
        out_ready = 1'b1;
        guard = 0;
        last_accept = 1'b0;
        while (!last_accept && guard < 10) begin
            step();
            guard++;
        end
        chk("stall_third_accepted", last_accept, 1'b1);
        in_valid = 1'b0;
        step();
        step();
        chk("stall_in_ready_back", in_ready, 1'b1);
        chk("small_saturated", s_wr_count, 2'd3);

        // Address-0 write.
        apply_stimulus(1'b1, 2'b01, 0, 5, 1'b1);
        step();
        chk("zero_vec", we_vec, ZERO_MASK ? 32'h0 : 32'h1);
        in_valid = 1'b0;
        step();

        // Fill OUT and SKID, then reset mid-stall.
        apply_stimulus(1'b1, 2'b10, 0, 7, 1'b0);
        step();
        apply_stimulus(1'b1, 2'b11, 11, 12, 1'b0);
        step();
        in_valid = 1'b0;
        step();
        #2 reset = 1'b1;
        #1;
        check_reset_state("mid_stall");
        exp_q.delete();
        cnt = 0;
        @(posedge clk);
        #1 check_reset_state("held");
        @(negedge clk);
        #2 reset = 1'b0;
        out_ready = 1'b1;
        #1 chk("post_reset_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        step();
        step();

        // Randomized traffic with forced collisions and address-0 writes.
        for (int i = 0; i < 400; i++) begin
            a0 = int'($urandom_range(0, NREG - 1));
            a1 = int'($urandom_range(0, NREG - 1));
            if ($urandom_range(0, 3) == 0) a1 = a0;
            if ($urandom_range(0, 7) == 0) a0 = 0;
            apply_stimulus($urandom_range(0, 3) != 0, PORTS'($urandom_range(0, 3)),
                           a0, a1, $urandom_range(0, 2) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
